// File: rtl/tile_sequencer_pkg.sv
// Shared definitions for the tile sequencer: phase encodings and default widths.
// The phase encoding is visible on the sequencer's state output.
package tile_sequencer_pkg;

   localparam int TILE_CNT_W_DEF = 8;
   localparam int WORD_CNT_W_DEF = 12;
   localparam int PERF_W_DEF     = 32;

   // IDLE is zero so that a reset state reads back as all-zero outputs.
   typedef enum logic [2:0] {
      IDLE = 3'd0,
      PREP = 3'd1,
      TRAN = 3'd2,
      COMP = 3'd3
   } seq_state_e;

endpackage

// File: rtl/tile_sequencer_if.sv
// Read-request port between the tile sequencer (master) and the memory side (slave).
// Ports: rd_req_valid/ready handshake, rd_req_tile/word index, rd_data_valid return strobe.
interface tile_sequencer_if #(
   parameter int TILE_CNT_W = 8,
   parameter int WORD_CNT_W = 12
);

   logic                  rd_req_valid;
   logic                  rd_req_ready;
   logic [TILE_CNT_W-1:0] rd_req_tile;
   logic [WORD_CNT_W-1:0] rd_req_word;
   logic                  rd_data_valid;

   modport master (
      output rd_req_valid,
      output rd_req_tile,
      output rd_req_word,
      input  rd_req_ready,
      input  rd_data_valid
   );

   modport slave (
      input  rd_req_valid,
      input  rd_req_tile,
      input  rd_req_word,
      output rd_req_ready,
      output rd_data_valid
   );

endinterface

// File: rtl/tile_word_counter.sv
// Request/return word counters for one tile; returns saturate at the word count.
// Ports: clk, reset (sync, active-low), clr, active, words, req_ready, ret_valid,
//        req_cnt, req_pending, ret_last.
module tile_word_counter
   import tile_sequencer_pkg::*;
#(
   parameter int WORD_CNT_W = WORD_CNT_W_DEF
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  clr,
   input  logic                  active,
   input  logic [WORD_CNT_W-1:0] words,
   input  logic                  req_ready,
   input  logic                  ret_valid,
   output logic [WORD_CNT_W-1:0] req_cnt,
   output logic                  req_pending,
   output logic                  ret_last
);

   logic [WORD_CNT_W-1:0] ret_cnt;
   logic [WORD_CNT_W-1:0] ret_nxt;
   logic                  ret_full;
   logic                  ret_take;

   assign req_pending = active && (req_cnt < words);
   assign ret_full    = (ret_cnt == words);
   assign ret_take    = active && ret_valid && !ret_full;
   assign ret_nxt     = ret_cnt + 1'b1;

   // Exit condition counts a return landing in the current cycle.
   assign ret_last = active &&
                     (ret_full || (ret_take && (ret_nxt == words)));

   always_ff @(posedge clk) begin
      if (!reset) begin
         req_cnt <= '0;
         ret_cnt <= '0;
      end else if (clr) begin
         req_cnt <= '0;
         ret_cnt <= '0;
      end else begin
         if (req_pending && req_ready)
            req_cnt <= req_cnt + 1'b1;
         if (ret_take)
            ret_cnt <= ret_nxt;
      end
   end

endmodule

// File: rtl/tile_sequencer.sv
// Sequences one layer of tiles through PREP -> TRAN -> COMP; FSM plus tile counter.
// Ports: clk, reset (sync, active-low), start, num_tiles, words_per_tile,
//        cfg_req/cfg_ack, rd (read-request interface, master), comp_start/comp_done,
//        busy, done, state, stall_cycles.
// Optional: define TILE_SEQ_PERF_EN to enable the saturating stall counter.
module tile_sequencer
   import tile_sequencer_pkg::*;
#(
   parameter int TILE_CNT_W = TILE_CNT_W_DEF,
   parameter int WORD_CNT_W = WORD_CNT_W_DEF,
   parameter int PERF_W     = PERF_W_DEF
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [TILE_CNT_W-1:0] num_tiles,
   input  logic [WORD_CNT_W-1:0] words_per_tile,
   output logic                  cfg_req,
   input  logic                  cfg_ack,
   tile_sequencer_if.master      rd,
   output logic                  comp_start,
   input  logic                  comp_done,
   output logic                  busy,
   output logic                  done,
   output logic [2:0]            state,
   output logic [PERF_W-1:0]     stall_cycles
);

   seq_state_e            state_q;
   seq_state_e            state_d;
   logic [TILE_CNT_W-1:0] tiles_q;
   logic [WORD_CNT_W-1:0] words_q;
   logic [TILE_CNT_W-1:0] tile_idx;
   logic [WORD_CNT_W-1:0] req_cnt;
   logic                  req_pending;
   logic                  ret_last;
   logic                  in_tran;
   logic                  last_tile;
   logic                  accept;
   logic                  clr;
   logic                  tile_inc;
   logic                  done_set;
   logic                  done_q;
   logic                  comp_start_q;

   assign in_tran   = (state_q == TRAN);
   assign last_tile = (tile_idx == tiles_q - 1'b1);

   tile_word_counter #(
      .WORD_CNT_W (WORD_CNT_W)
   ) u_cnt (
      .clk         (clk),
      .reset       (reset),
      .clr         (clr),
      .active      (in_tran),
      .words       (words_q),
      .req_ready   (rd.rd_req_ready),
      .ret_valid   (rd.rd_data_valid),
      .req_cnt     (req_cnt),
      .req_pending (req_pending),
      .ret_last    (ret_last)
   );

   always_comb begin
      state_d  = state_q;
      accept   = 1'b0;
      clr      = 1'b0;
      tile_inc = 1'b0;
      done_set = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               accept = 1'b1;
               clr    = 1'b1;
               // An empty layer completes without touching the config path.
               if (num_tiles == '0)
                  done_set = 1'b1;
               else
                  state_d = PREP;
            end
         end
         PREP: begin
            if (cfg_ack)
               state_d = TRAN;
         end
         TRAN: begin
            if (ret_last)
               state_d = COMP;
         end
         COMP: begin
            if (comp_done) begin
               clr = 1'b1;
               if (last_tile) begin
                  state_d  = IDLE;
                  done_set = 1'b1;
               end else begin
                  state_d  = TRAN;
                  tile_inc = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q      <= IDLE;
         tiles_q      <= '0;
         words_q      <= '0;
         tile_idx     <= '0;
         done_q       <= 1'b0;
         comp_start_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         done_q       <= done_set;
         // Registered so comp_start has no path from comp_done/rd inputs.
         comp_start_q <= (state_d == COMP) && (state_q != COMP);
         if (accept) begin
            tiles_q  <= num_tiles;
            words_q  <= words_per_tile;
            tile_idx <= '0;
         end else if (tile_inc) begin
            tile_idx <= tile_idx + 1'b1;
         end
      end
   end

   assign cfg_req         = (state_q == PREP);
   assign rd.rd_req_valid = req_pending;
   assign rd.rd_req_tile  = in_tran ? tile_idx : '0;
   assign rd.rd_req_word  = in_tran ? req_cnt : '0;
   assign comp_start      = comp_start_q;
   assign busy            = (state_q != IDLE);
   assign done            = done_q;
   assign state           = state_q;

`ifdef TILE_SEQ_PERF_EN
   logic [PERF_W-1:0] stall_q;

   always_ff @(posedge clk) begin
      if (!reset)
         stall_q <= '0;
      else if (accept)
         stall_q <= '0;
      else if (req_pending && !rd.rd_req_ready && (stall_q != '1))
         stall_q <= stall_q + 1'b1;
   end

   assign stall_cycles = stall_q;
`else
   assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_tile_sequencer.sv
// Self-checking bench for tile_sequencer with a request scoreboard.
// Responders for cfg_ack, rd_req_ready, rd_data_valid and comp_done run on negedge.
module tb_tile_sequencer;
   import tile_sequencer_pkg::*;

   localparam int TW = 8;
   localparam int WW = 12;
   localparam int PW = 32;

   typedef struct packed {
      logic [TW-1:0] tile;
      logic [WW-1:0] word;
   } req_t;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          start = 1'b0;
   logic [TW-1:0] num_tiles = '0;
   logic [WW-1:0] words = '0;
   logic          cfg_req;
   logic          cfg_ack;
   logic          comp_start;
   logic          comp_done;
   logic          busy;
   logic          done;
   logic [2:0]    state;
   logic [PW-1:0] stall_cycles;

   int   vectors = 0;
   int   miscompares = 0;
   int   hs_cnt = 0;
   int   cs_cnt = 0;
   int   done_cnt = 0;
   int   cfg_cnt = 0;
   int   tran_cnt = 0;
   bit   tog_ready = 0;
   bit   extra_dv_en = 0;
   int   comp_delay = 0;
   req_t exp_q[$];

   tile_sequencer_if #(.TILE_CNT_W(TW), .WORD_CNT_W(WW)) bus ();

   tile_sequencer #(
      .TILE_CNT_W (TW),
      .WORD_CNT_W (WW),
      .PERF_W     (PW)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .start          (start),
      .num_tiles      (num_tiles),
      .words_per_tile (words),
      .cfg_req        (cfg_req),
      .cfg_ack        (cfg_ack),
      .rd             (bus),
      .comp_start     (comp_start),
      .comp_done      (comp_done),
      .busy           (busy),
      .done           (done),
      .state          (state),
      .stall_cycles   (stall_cycles)
   );

   always #5 clk = ~clk;

   // Responders and scoreboard consumer, all on the falling edge.
   initial begin
      bit       ph;
      bit [2:0] pipe;
      int       ccnt;
      bit       hs;
      req_t     e;
      ph = 1;
      pipe = '0;
      ccnt = 0;
      bus.rd_req_ready = 1'b0;
      bus.rd_data_valid = 1'b0;
      cfg_ack = 1'b0;
      comp_done = 1'b0;
      forever begin
         @(negedge clk);
         if (!reset) begin
            pipe = '0;
            ccnt = 0;
            ph = 1;
         end
         if (tog_ready && state == TRAN) begin
            bus.rd_req_ready = ph;
            ph = ~ph;
         end else begin
            bus.rd_req_ready = 1'b1;
            ph = 1;
         end
         cfg_ack = cfg_req;
         comp_done = 1'b0;
         if (ccnt != 0) begin
            ccnt--;
            if (ccnt == 0) comp_done = 1'b1;
         end
         if (comp_start) begin
            if (comp_delay == 0) comp_done = 1'b1;
            else ccnt = comp_delay;
         end
         hs = bus.rd_req_valid && bus.rd_req_ready && reset;
         pipe = {pipe[1:0], hs};
         bus.rd_data_valid = pipe[2] | (extra_dv_en && state == COMP);
         if (comp_start) cs_cnt++;
         if (done) done_cnt++;
         if (cfg_req) cfg_cnt++;
         if (state == TRAN) tran_cnt++;
         if (hs) begin
            hs_cnt++;
            vectors++;
            if (exp_q.size() == 0) begin
               miscompares++;
               $display("FAIL req_unexpected: got tile %0d word %0d, none expected",
                        bus.rd_req_tile, bus.rd_req_word);
            end else begin
               e = exp_q.pop_front();
               if (bus.rd_req_tile !== e.tile || bus.rd_req_word !== e.word) begin
                  miscompares++;
                  $display("FAIL req_index: got tile %0d word %0d, expected tile %0d word %0d",
                           bus.rd_req_tile, bus.rd_req_word, e.tile, e.word);
               end
            end
         end
      end
   end

   task automatic tick;
      @(posedge clk);
      #2;
   endtask

   task automatic clear_counts;
      hs_cnt = 0;
      cs_cnt = 0;
      done_cnt = 0;
      cfg_cnt = 0;
      tran_cnt = 0;
   endtask

   task automatic run_layer(input int n, input int w);
      start = 1'b1;
      num_tiles = TW'(n);
      words = WW'(w);
      for (int t = 0; t < n; t++)
         for (int k = 0; k < w; k++)
            exp_q.push_back('{tile: TW'(t), word: WW'(k)});
      tick;
      start = 1'b0;
   endtask

   task automatic wait_done(input int budget, input string name);
      int i;
      i = 0;
      while (done_cnt == 0 && i < budget) begin
         tick;
         i++;
      end
      vectors++;
      if (done_cnt == 0) begin
         miscompares++;
         $display("FAIL %s_timeout: got no done, expected done within %0d cycles", name, budget);
      end
   endtask

   task automatic test_reset;
      reset = 1'b0;
      repeat (3) tick;
      vectors++;
      if (state !== 3'd0) begin
         miscompares++;
         $display("FAIL reset_state: got %0d expected 0", state);
      end
      vectors++;
      if ({cfg_req, bus.rd_req_valid, comp_start, busy, done} !== 5'b0) begin
         miscompares++;
         $display("FAIL reset_outputs: got %b expected 00000",
                  {cfg_req, bus.rd_req_valid, comp_start, busy, done});
      end
      vectors++;
      if (stall_cycles !== '0) begin
         miscompares++;
         $display("FAIL reset_stall: got %0d expected 0", stall_cycles);
      end
      reset = 1'b1;
      tick;
   endtask

   task automatic test_basic;
      clear_counts();
      run_layer(2, 4);
      vectors++;
      if (state !== 3'(PREP) || cfg_req !== 1'b1) begin
         miscompares++;
         $display("FAIL basic_prep: got state %0d cfg_req %b expected 1 1", state, cfg_req);
      end
      wait_done(100, "basic");
      tick;
      vectors++;
      if (hs_cnt != 8) begin
         miscompares++;
         $display("FAIL basic_reqs: got %0d expected 8", hs_cnt);
      end
      vectors++;
      if (cs_cnt != 2) begin
         miscompares++;
         $display("FAIL basic_comp_start: got %0d expected 2", cs_cnt);
      end
      vectors++;
      if (done_cnt != 1 || cfg_cnt != 1) begin
         miscompares++;
         $display("FAIL basic_done_cfg: got done %0d cfg %0d expected 1 1", done_cnt, cfg_cnt);
      end
      vectors++;
      if (exp_q.size() != 0 || busy !== 1'b0) begin
         miscompares++;
         $display("FAIL basic_end: got pending %0d busy %b expected 0 0", exp_q.size(), busy);
      end
   endtask

   task automatic test_zero_tiles;
      clear_counts();
      run_layer(0, 5);
      vectors++;
      if (done !== 1'b1 || state !== 3'd0) begin
         miscompares++;
         $display("FAIL zero_tiles_done: got done %b state %0d expected 1 0", done, state);
      end
      tick;
      vectors++;
      if (done !== 1'b0) begin
         miscompares++;
         $display("FAIL zero_tiles_pulse: got done %b expected 0", done);
      end
      repeat (3) tick;
      vectors++;
      if (cfg_cnt != 0 || hs_cnt != 0 || done_cnt != 1 || busy !== 1'b0) begin
         miscompares++;
         $display("FAIL zero_tiles_quiet: got cfg %0d reqs %0d done %0d busy %b expected 0 0 1 0",
                  cfg_cnt, hs_cnt, done_cnt, busy);
      end
   endtask

   task automatic test_zero_words;
      clear_counts();
      run_layer(3, 0);
      wait_done(100, "zero_words");
      tick;
      vectors++;
      if (cs_cnt != 3 || hs_cnt != 0) begin
         miscompares++;
         $display("FAIL zero_words_counts: got comp_start %0d reqs %0d expected 3 0", cs_cnt, hs_cnt);
      end
      vectors++;
      if (tran_cnt != 3) begin
         miscompares++;
         $display("FAIL zero_words_tran: got %0d TRAN cycles expected 3", tran_cnt);
      end
   endtask

   task automatic test_stall;
      logic [PW-1:0] exp_stall;
`ifdef TILE_SEQ_PERF_EN
      exp_stall = PW'(7);
`else
      exp_stall = '0;
`endif
      clear_counts();
      tog_ready = 1;
      run_layer(1, 8);
      wait_done(200, "stall");
      tick;
      tog_ready = 0;
      vectors++;
      if (hs_cnt != 8) begin
         miscompares++;
         $display("FAIL stall_reqs: got %0d expected 8", hs_cnt);
      end
      vectors++;
      if (stall_cycles !== exp_stall) begin
         miscompares++;
         $display("FAIL stall_count: got %0d expected %0d", stall_cycles, exp_stall);
      end
   endtask

   task automatic test_mid_reset;
      int i;
      clear_counts();
      run_layer(2, 8);
      i = 0;
      while (hs_cnt < 3 && i < 50) begin
         tick;
         i++;
      end
      vectors++;
      if (state !== 3'(TRAN) || bus.rd_req_word !== WW'(3) || bus.rd_req_tile !== TW'(0)) begin
         miscompares++;
         $display("FAIL mid_reset_pre: got state %0d tile %0d word %0d expected 2 0 3",
                  state, bus.rd_req_tile, bus.rd_req_word);
      end
      reset = 1'b0;
      tick;
      vectors++;
      if (state !== 3'd0) begin
         miscompares++;
         $display("FAIL mid_reset_state: got %0d expected 0", state);
      end
      vectors++;
      if ({cfg_req, bus.rd_req_valid, bus.rd_req_tile, bus.rd_req_word,
           comp_start, busy, done, stall_cycles} !== '0) begin
         miscompares++;
         $display("FAIL mid_reset_outputs: got valid %b tile %0d word %0d busy %b done %b expected all 0",
                  bus.rd_req_valid, bus.rd_req_tile, bus.rd_req_word, busy, done);
      end
      reset = 1'b1;
      exp_q.delete();
      tick;
      clear_counts();
      run_layer(1, 2);
      wait_done(100, "mid_reset_rerun");
      tick;
      vectors++;
      if (hs_cnt != 2 || cs_cnt != 1) begin
         miscompares++;
         $display("FAIL mid_reset_rerun: got reqs %0d comp_start %0d expected 2 1", hs_cnt, cs_cnt);
      end
   endtask

   task automatic test_back_to_back;
      int i;
      clear_counts();
      comp_delay = 2;
      extra_dv_en = 1;
      run_layer(3, 2);
      i = 0;
      while (state !== 3'(TRAN) && i < 20) begin
         tick;
         i++;
      end
      start = 1'b1;
      num_tiles = TW'(7);
      tick;
      tick;
      start = 1'b0;
      wait_done(200, "b2b");
      repeat (4) tick;
      comp_delay = 0;
      extra_dv_en = 0;
      vectors++;
      if (hs_cnt != 6 || cs_cnt != 3) begin
         miscompares++;
         $display("FAIL b2b_counts: got reqs %0d comp_start %0d expected 6 3", hs_cnt, cs_cnt);
      end
      vectors++;
      if (done_cnt != 1 || cfg_cnt != 1 || busy !== 1'b0) begin
         miscompares++;
         $display("FAIL b2b_single: got done %0d cfg %0d busy %b expected 1 1 0",
                  done_cnt, cfg_cnt, busy);
      end
      vectors++;
      if (exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL b2b_pending: got %0d expected 0", exp_q.size());
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_zero_tiles();
      test_zero_words();
      test_stall();
      test_mid_reset();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
